matrix_rows_gen: RTL

Three-row window source for the 3x3 neighbourhood filters (dilate/erode). Accepts a raster pixel stream and emits, per accepted pixel, that pixel plus the pixels at the same column one and two lines above. These three outputs feed directly into the `din3`/`din2`/`din1` inputs of the 3x3 matrix stage. Two internal line memories of `PIC_WIDTH` entries each hold the previous two lines. Rows above the image top are zero-padded.

---
 rtl/matrix_rows_gen.sv | 65 ++++++
 1 files changed

// File: rtl/matrix_rows_gen.sv
// matrix_rows_gen: three-row window source (row-2, row-1, row) for 3x3 neighbourhood filters
module matrix_rows_gen #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 320,
    parameter int PIC_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eol_out,
    output logic             eof_out
);
    localparam int AW = $clog2(PIC_WIDTH);
    localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
    localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);

    logic [8:0] col, row;
    logic [WIDTH-1:0] lb1 [PIC_WIDTH];
    logic [WIDTH-1:0] lb2 [PIC_WIDTH];
    logic [AW-1:0] addr;
    logic last_col, last_row;

    assign addr     = col[AW-1:0];
    assign last_col = col == COL_LAST;
    assign last_row = row == ROW_LAST;

    // Line memories: shift the column's one-line-back pixel down to two-lines-back, store the new pixel
    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            lb2[addr] <= din;
            lb1[addr] <= lb2[addr];
        end
    end

    // Raster counters and window outputs; stale memory above the frame top is masked by row
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
            dout1     <= '0;
            dout2     <= '0;
            dout3     <= '0;
        end else begin
            valid_out <= valid_in;
            eol_out   <= valid_in && last_col;
            eof_out   <= valid_in && last_col && last_row;
            if (valid_in) begin
                dout3 <= din;
                dout2 <= (row >= 9'd1) ? lb2[addr] : '0;
                dout1 <= (row >= 9'd2) ? lb1[addr] : '0;
                col   <= last_col ? '0 : col + 9'd1;
                if (last_col)
                    row <= last_row ? '0 : row + 9'd1;
            end
        end
    end
endmodule
